// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shift_arbiter block: FSM state encoding,
// datapath widths and the rotate-complement helper.
package shift_arb_pkg;

    localparam int DATA_W  = 8;
    localparam int SHAMT_W = 3;
    localparam int ID_W    = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ROT2 = 2'd2,
        RESP = 2'd3
    } state_t;

    // Second-pass amount for a rotate: DATA_W - shamt, wrapped to SHAMT_W bits.
    function automatic logic [SHAMT_W-1:0] rot_comp(input logic [SHAMT_W-1:0] shamt);
        return SHAMT_W'(DATA_W - int'(shamt));
    endfunction

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Combinational logarithmic barrel shifter: logical shift left (i_dir=0) or
// right (i_dir=1), zero fill, one mux stage per shift-amount bit.
module Bidirectional_Barrel_Shifter #(
    parameter int W = 8,
    parameter int S = 3
) (
    input  logic [W-1:0] i_data,
    input  logic [S-1:0] i_shamt,
    input  logic         i_dir,
    output logic [W-1:0] o_data
);

    logic [W-1:0] w_stage;

    // NOTE: blocking assignments here are deliberate; each stage reads the
    // value the previous loop iteration just produced, which is pure logic.
    always_comb begin
        w_stage = i_data;
        for (int k = 0; k < S; k++) begin
            if (i_shamt[k]) begin
                w_stage = i_dir ? (w_stage >> (1 << k)) : (w_stage << (1 << k));
            end
        end
        o_data = w_stage;
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin front end sharing one barrel shifter between two requesters.
// Define SHIFT_ARB_ROTATE_EN to enable two-pass rotates (ROT2 state).
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int RESET_PRIO = 0
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               s0_valid,
    output logic               s0_ready,
    input  logic [DATA_W-1:0]  s0_data,
    input  logic [SHAMT_W-1:0] s0_shamt,
    input  logic               s0_dir,
    input  logic               s0_rot,

    input  logic               s1_valid,
    output logic               s1_ready,
    input  logic [DATA_W-1:0]  s1_data,
    input  logic [SHAMT_W-1:0] s1_shamt,
    input  logic               s1_dir,
    input  logic               s1_rot,

    output logic               m_valid,
    input  logic               m_ready,
    output logic [DATA_W-1:0]  m_data,
    output logic [ID_W-1:0]    m_id,
    output logic               busy
);

    localparam logic [ID_W-1:0] LAST_GRANT_RST = (RESET_PRIO == 0) ? ID_W'(1) : ID_W'(0);

    state_t              r_state;
    state_t              w_next_state;

    logic [DATA_W-1:0]   r_data;
    logic [SHAMT_W-1:0]  r_shamt;
    logic                r_dir;
    logic [ID_W-1:0]     r_id;
    logic [ID_W-1:0]     r_last_grant;
    logic [DATA_W-1:0]   r_acc;
`ifdef SHIFT_ARB_ROTATE_EN
    logic                r_rot;
    logic                w_sel_rot;
`else
    logic                w_unused_rot;
`endif

    logic [ID_W-1:0]     w_grant_id;
    logic                w_accept;
    logic [DATA_W-1:0]   w_sel_data;
    logic [SHAMT_W-1:0]  w_sel_shamt;
    logic                w_sel_dir;

    logic [SHAMT_W-1:0]  w_sh_shamt;
    logic                w_sh_dir;
    logic [DATA_W-1:0]   w_sh_out;

    // ------------------------------------------------------------------
    // Arbiter: a lone requester wins; on a tie the one not granted last wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_id = ID_W'(0);
        if (s0_valid && s1_valid) begin
            w_grant_id = ~r_last_grant;
        end else if (s1_valid) begin
            w_grant_id = ID_W'(1);
        end
    end

    // rst_n gates ready so nothing is offered while reset is held.
    always_comb begin
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        if (rst_n && (r_state == IDLE)) begin
            s0_ready = s0_valid && (w_grant_id == ID_W'(0));
            s1_ready = s1_valid && (w_grant_id == ID_W'(1));
        end
    end

    assign w_accept    = s0_ready | s1_ready;
    assign w_sel_data  = (w_grant_id == ID_W'(1)) ? s1_data  : s0_data;
    assign w_sel_shamt = (w_grant_id == ID_W'(1)) ? s1_shamt : s0_shamt;
    assign w_sel_dir   = (w_grant_id == ID_W'(1)) ? s1_dir   : s0_dir;
`ifdef SHIFT_ARB_ROTATE_EN
    assign w_sel_rot   = (w_grant_id == ID_W'(1)) ? s1_rot   : s0_rot;
`else
    assign w_unused_rot = s0_rot ^ s1_rot;
`endif

    // ------------------------------------------------------------------
    // FSM: state register and next-state / shifter-control logic.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_sh_shamt   = r_shamt;
        w_sh_dir     = r_dir;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
`ifdef SHIFT_ARB_ROTATE_EN
                if (r_rot && (r_shamt != '0)) begin
                    w_next_state = ROT2;
                end else begin
                    w_next_state = RESP;
                end
`else
                w_next_state = RESP;
`endif
            end
`ifdef SHIFT_ARB_ROTATE_EN
            ROT2: begin
                // Rotate = (x << n) | (x >> (W-n)), built over two passes.
                w_sh_shamt   = rot_comp(r_shamt);
                w_sh_dir     = ~r_dir;
                w_next_state = RESP;
            end
`endif
            RESP: begin
                if (m_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    Bidirectional_Barrel_Shifter #(
        .W (DATA_W),
        .S (SHAMT_W)
    ) u_shifter (
        .i_data  (r_data),
        .i_shamt (w_sh_shamt),
        .i_dir   (w_sh_dir),
        .o_data  (w_sh_out)
    );

    // ------------------------------------------------------------------
    // Datapath: operand capture on handshake, accumulate shifter passes.
    // ------------------------------------------------------------------
    // NOTE: every register, including the result, resets so m_data/m_id read
    // zero after reset and an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data       <= '0;
            r_shamt      <= '0;
            r_dir        <= 1'b0;
            r_id         <= '0;
            r_last_grant <= LAST_GRANT_RST;
            r_acc        <= '0;
`ifdef SHIFT_ARB_ROTATE_EN
            r_rot        <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_data       <= w_sel_data;
                r_shamt      <= w_sel_shamt;
                r_dir        <= w_sel_dir;
                r_id         <= w_grant_id;
                r_last_grant <= w_grant_id;
`ifdef SHIFT_ARB_ROTATE_EN
                r_rot        <= w_sel_rot;
`endif
            end
            if (r_state == EXEC) begin
                r_acc <= w_sh_out;
            end
`ifdef SHIFT_ARB_ROTATE_EN
            if (r_state == ROT2) begin
                r_acc <= r_acc | w_sh_out;
            end
`endif
        end
    end

    assign m_valid = (r_state == RESP);
    assign m_data  = r_acc;
    assign m_id    = r_id;
    assign busy    = (r_state != IDLE);

endmodule
